// File: rtl/seg_digit_scanner_pkg.sv
// Shared display definitions for the 4-digit seven-segment scan logic.
package seg_digit_scanner_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0]            digit_idx_t;
  typedef logic [NUM_DIGITS-1:0] anode_t;

  // All digits dark (anodes are active-low).
  localparam anode_t ANODE_OFF = 4'b1111;

  // Digit indices as seen on the segment-mux select lines.
  localparam digit_idx_t DIG_0 = 2'd0;
  localparam digit_idx_t DIG_1 = 2'd1;
  localparam digit_idx_t DIG_2 = 2'd2;
  localparam digit_idx_t DIG_3 = 2'd3;

  // Active-low anode pattern with only the indexed digit lit.
  function automatic anode_t onehot_low(input digit_idx_t idx);
    anode_t pat;
    pat      = ANODE_OFF;
    pat[idx] = 1'b0;
    return pat;
  endfunction

endpackage

// File: rtl/seg_digit_scanner_tick.sv
// Mod-N counter with count enable, synchronous clear and a wrap pulse.
// The wrap pulse is combinational and is high in the cycle whose clock
// edge takes the counter from N-1 back to 0.
module tick_divider #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_next;

  // Next count: clear wins, otherwise advance on enable and fold at N-1.
  always_comb begin
    wrap       = 1'b0;
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (en) begin
      if (count == LAST) begin
        wrap       = 1'b1;
        count_next = '0;
      end else begin
        count_next = count + W'(1);
      end
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/seg_digit_scanner.sv
// Time-multiplexing scan controller for a 4-digit seven-segment display.
// Walks select through digits 0..3, one SCAN_DIV-cycle slot each, and drives
// active-low anodes with a dark dead time at the start of every slot plus
// per-digit enable and blink masking. Every output comes straight from a flop.
module seg_digit_scanner
  import seg_digit_scanner_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int DEAD_CYCLES = 64,
  parameter int BLINK_DIV   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_en,
  input  logic       blink_en,
  input  logic [3:0] blink_mask,
  output logic [1:0] select,
  output logic [3:0] anode,
  output logic       scan_tick,
  output logic       blink_phase
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0] p_count;
  logic [PW-1:0] p_next;
  logic          p_wrap;
  logic [BW-1:0] blink_count;
  logic          blink_wrap;
  logic          unused_blink_count;

  digit_idx_t    select_next;
  logic          phase_next;
  logic          in_dead;
  anode_t        anode_next;

  // Slot prescaler: free-running, wraps once per digit slot.
  tick_divider #(
    .N (SCAN_DIV),
    .W (PW)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clear (1'b0),
    .count (p_count),
    .wrap  (p_wrap)
  );

  // Blink counter: counts slots while blinking is on, parked at 0 otherwise,
  // so a re-enabled blink always begins with a full visible half-period.
  tick_divider #(
    .N (BLINK_DIV),
    .W (BW)
  ) u_blink_counter (
    .clk   (clk),
    .reset (reset),
    .en    (scan_tick),
    .clear (~blink_en),
    .count (blink_count),
    .wrap  (blink_wrap)
  );

  // Only the wrap pulse of the blink counter matters here.
  assign unused_blink_count = ^blink_count;

  // The anode register must reflect the prescaler value it will sit beside,
  // so the dead-time test is done on the prescaler's next value.
  assign p_next = p_wrap ? '0 : PW'(p_count + PW'(1));

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      localparam logic [PW-1:0] DEAD_LIM = PW'(DEAD_CYCLES);
      assign in_dead = (p_next < DEAD_LIM);
    end
  endgenerate

  // Next select, blink phase and anode pattern, all aligned to the next cycle.
  always_comb begin
    select_next = p_wrap ? digit_idx_t'(select + 2'd1) : select;
    phase_next  = blink_en ? (blink_phase ^ blink_wrap) : 1'b0;
    anode_next  = ANODE_OFF;
    if (!in_dead && digit_en[select_next] &&
        !(blink_en && phase_next && blink_mask[select_next])) begin
      anode_next = onehot_low(select_next);
    end
  end

  // Output registers; reset forces a dark display at digit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      select      <= DIG_0;
      anode       <= ANODE_OFF;
      scan_tick   <= 1'b0;
      blink_phase <= 1'b0;
    end else begin
      select      <= select_next;
      anode       <= anode_next;
      scan_tick   <= p_wrap;
      blink_phase <= phase_next;
    end
  end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Self-checking bench for seg_digit_scanner: two instances (scaled defaults
// and a no-dead-time, fast-blink variant) compared every cycle to a model
// built from elapsed cycle and tick counts.
module tb_seg_digit_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit_en = 4'hF;
  logic       blink_en = 1'b0;
  logic [3:0] blink_mask = 4'h0;

  logic [1:0] a_select, b_select;
  logic [3:0] a_anode, b_anode;
  logic       a_scan_tick, b_scan_tick;
  logic       a_blink_phase, b_blink_phase;

  int testCount = 0;
  int failCount = 0;

  // Model parameters per instance (0 = dut_a, 1 = dut_b).
  int sdiv[2] = '{8, 2};
  int dead[2] = '{2, 0};
  int bdiv[2] = '{4, 1};

  // Model state: cycles since reset, scan ticks seen while blinking enabled.
  int         mt[2];
  int         mticks[2];
  logic       mtick[2];
  logic       mphase[2];
  logic [3:0] manode[2];

  seg_digit_scanner #(
    .SCAN_DIV    (8),
    .DEAD_CYCLES (2),
    .BLINK_DIV   (4)
  ) dut_a (
    .clk         (clk),
    .reset       (reset),
    .digit_en    (digit_en),
    .blink_en    (blink_en),
    .blink_mask  (blink_mask),
    .select      (a_select),
    .anode       (a_anode),
    .scan_tick   (a_scan_tick),
    .blink_phase (a_blink_phase)
  );

  seg_digit_scanner #(
    .SCAN_DIV    (2),
    .DEAD_CYCLES (0),
    .BLINK_DIV   (1)
  ) dut_b (
    .clk         (clk),
    .reset       (reset),
    .digit_en    (digit_en),
    .blink_en    (blink_en),
    .blink_mask  (blink_mask),
    .select      (b_select),
    .anode       (b_anode),
    .scan_tick   (b_scan_tick),
    .blink_phase (b_blink_phase)
  );

  always #5 clk = ~clk;

  // Anode rules expressed directly on slot position and digit index.
  function automatic logic [3:0] refAnode(input int p, input int sel, input int dc,
                                          input logic [3:0] den, input logic ben,
                                          input logic [3:0] bm, input logic ph);
    if (p < dc) return 4'hF;
    if (!den[sel]) return 4'hF;
    if (ben && ph && bm[sel]) return 4'hF;
    return 4'hF & ~(4'h1 << sel);
  endfunction

  // Advance the model across one rising edge using the pre-edge inputs.
  task automatic modelStep(input int i);
    if (reset) begin
      mt[i]     = 0;
      mticks[i] = 0;
    end else begin
      mticks[i] = blink_en ? mticks[i] + (mtick[i] ? 1 : 0) : 0;
      mt[i]     = mt[i] + 1;
    end
    mtick[i]  = (mt[i] > 0) && (mt[i] % sdiv[i] == 0);
    mphase[i] = ((mticks[i] / bdiv[i]) % 2) == 1;
    manode[i] = reset ? 4'hF :
                refAnode(mt[i] % sdiv[i], (mt[i] / sdiv[i]) % 4, dead[i],
                         digit_en, blink_en, blink_mask, mphase[i]);
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] den,
                               input logic ben, input logic [3:0] bm);
    reset      = rst;
    digit_en   = den;
    blink_en   = ben;
    blink_mask = bm;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("a.select", {2'b00, a_select}, {2'b00, 2'((mt[0] / sdiv[0]) % 4)});
    checkOutput("a.anode", a_anode, manode[0]);
    checkOutput("a.scan_tick", {3'b000, a_scan_tick}, {3'b000, mtick[0]});
    checkOutput("a.blink_phase", {3'b000, a_blink_phase}, {3'b000, mphase[0]});
    checkOutput("a.anode_onehot", {3'b000, ($countones(~a_anode) <= 1)}, 4'b0001);
    checkOutput("b.select", {2'b00, b_select}, {2'b00, 2'((mt[1] / sdiv[1]) % 4)});
    checkOutput("b.anode", b_anode, manode[1]);
    checkOutput("b.scan_tick", {3'b000, b_scan_tick}, {3'b000, mtick[1]});
    checkOutput("b.blink_phase", {3'b000, b_blink_phase}, {3'b000, mphase[1]});
  endtask

  task automatic runCycle();
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkAll();
  endtask

  initial begin
    logic       found;
    logic [3:0] rden;
    logic [3:0] rbm;
    logic       rben;

    mtick[0] = 1'b0;
    mtick[1] = 1'b0;

    // Reset and check the idle state.
    applyStimulus(1'b1, 4'hF, 1'b0, 4'h0);
    runCycle();
    runCycle();

    // Free run, all digits enabled.
    $display("[TB] free run, all digits");
    applyStimulus(1'b0, 4'hF, 1'b0, 4'h0);
    repeat (40) runCycle();

    // Alternate digits disabled.
    $display("[TB] digit_en = 1010");
    applyStimulus(1'b0, 4'b1010, 1'b0, 4'h0);
    repeat (32) runCycle();

    // Blink digit 0.
    $display("[TB] blink digit 0");
    applyStimulus(1'b0, 4'hF, 1'b1, 4'b0001);
    repeat (320) runCycle();

    // Drop blink_en while blanked, reassert three cycles later.
    $display("[TB] blink drop and re-enable");
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (mphase[0]) found = 1'b1;
      else runCycle();
    end
    checkOutput("wait_blank_phase", {3'b000, found}, 4'b0001);
    applyStimulus(1'b0, 4'hF, 1'b0, 4'b0001);
    repeat (3) runCycle();
    applyStimulus(1'b0, 4'hF, 1'b1, 4'b0001);
    repeat (100) runCycle();

    // Reset mid-slot at p = 5, select = 2.
    $display("[TB] mid-slot reset");
    applyStimulus(1'b0, 4'hF, 1'b0, 4'h0);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if ((mt[0] % 8 == 5) && ((mt[0] / 8) % 4 == 2)) found = 1'b1;
      else runCycle();
    end
    checkOutput("wait_mid_slot", {3'b000, found}, 4'b0001);
    applyStimulus(1'b1, 4'hF, 1'b0, 4'h0);
    runCycle();
    applyStimulus(1'b0, 4'hF, 1'b0, 4'h0);
    repeat (20) runCycle();

    // Randomized inputs with occasional resets.
    $display("[TB] random stimulus");
    rden = 4'hF;
    rbm  = 4'h0;
    rben = 1'b0;
    repeat (2000) begin
      if ($urandom_range(0, 19) == 0) rden = 4'($urandom);
      if ($urandom_range(0, 19) == 0) rbm = 4'($urandom);
      if ($urandom_range(0, 59) == 0) rben = ~rben;
      applyStimulus($urandom_range(0, 399) == 0, rden, rben, rbm);
      runCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
